seg7_scan: RTL and testbench

Four-digit multiplexed seven-segment display driver placed directly downstream of the 4-bit synchronous counters. It captures a 16-bit value (four hex nibbles, with counter output in the low nibble) on a load strobe and holds it in a pending register. The pending value moves to the displayed register only at a frame boundary, so the display never tears mid-frame. The block scans the digits with a programmable refresh prescaler, a per-slot anti-ghosting dead time, optional leading-zero blanking and per-digit decimal points.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/hex_to_seg7.sv | 20 ++
 rtl/seg7_scan.sv | 153 +++++++++++++++
 tb/tb_seg7_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the seven-segment scanner.
//                Holds the active-low hex-to-segment table ({g,f,e,d,c,b,a}),
//                the "all off" codes for segments and anodes, and the digit
//                count.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int NDIG = 4;

    typedef logic [3:0] nibble_t;
    typedef logic [1:0] dig_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low segment patterns, indexed by hex value 0..F.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Purely combinational nibble to active-low seven-segment
//                decoder.
//  Ports       : i_nibble  in  4  hex digit
//                o_seg_n   out 7  segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Four-digit multiplexed seven-segment display driver.
//                A value captured on `load` waits in a pending register and
//                is promoted to the displayed register only at a frame
//                boundary, so a frame is never torn. Each digit slot lasts
//                REFRESH_DIV cycles and begins with GHOST_CYC cycles of all
//                anodes off. Optional leading-zero blanking and per-digit
//                decimal points. All outputs are registered.
//  Params      : REFRESH_DIV  cycles per digit slot (>= 4)
//                GHOST_CYC    dark cycles at slot start (1 <= G < REFRESH_DIV)
//  Ports       : clk, rst (sync, active-high)
//                value_in   in  16  nibble k -> digit k (digit 0 rightmost)
//                load       in  1   capture strobe
//                blank_lz   in  1   leading-zero blanking enable (live)
//                dp_mask    in  4   decimal point enable per digit (live)
//                seg_n      out 7   segments {g..a}, active-low
//                dp_n       out 1   decimal point, active-low
//                an_n       out 4   anodes, active-low
//                frame_tick out 1   pulse after every completed frame
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PW-1:0] C_PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] C_GHOST_END = PW'(GHOST_CYC);

    logic [PW-1:0] r_pcnt;
    dig_idx_t      r_dig;
    logic [15:0]   r_pending;
    logic          r_pend_vld;
    logic [15:0]   r_active;

    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic [3:0]    r_an_n;
    logic          r_frame_tick;

    logic          w_slot_end;
    logic          w_frame_end;
    nibble_t       w_nibble;
    logic [6:0]    w_seg_dec;
    logic [3:0]    w_an_sel;
    logic          w_blanked;
    logic          w_lit;

    assign w_slot_end  = (r_pcnt == C_PCNT_LAST);
    assign w_frame_end = w_slot_end && (r_dig == 2'd3);

    // Digit mux, anode select and leading-zero blanking. A digit k >= 1 is
    // blanked only when it and every more-significant nibble are zero.
    always_comb begin
        w_nibble  = r_active[3:0];
        w_an_sel  = 4'b1110;
        w_blanked = 1'b0;
        case (r_dig)
            2'd0: begin
                w_nibble  = r_active[3:0];
                w_an_sel  = 4'b1110;
                w_blanked = 1'b0;
            end
            2'd1: begin
                w_nibble  = r_active[7:4];
                w_an_sel  = 4'b1101;
                w_blanked = blank_lz && (r_active[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble  = r_active[11:8];
                w_an_sel  = 4'b1011;
                w_blanked = blank_lz && (r_active[15:8] == 8'h00);
            end
            default: begin
                w_nibble  = r_active[15:12];
                w_an_sel  = 4'b0111;
                w_blanked = blank_lz && (r_active[15:12] == 4'h0);
            end
        endcase
    end

    assign w_lit = (r_pcnt >= C_GHOST_END) && !w_blanked;

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg_n  (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_dig        <= 2'd0;
            r_pending    <= 16'h0000;
            r_pend_vld   <= 1'b0;
            r_active     <= 16'h0000;
            r_seg_n      <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_an_n       <= AN_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_pcnt <= '0;
                r_dig  <= r_dig + 2'd1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            // A load coinciding with the boundary bypasses the pending
            // register so it is not delayed by a whole extra frame.
            if (w_frame_end) begin
                if (load) begin
                    r_active   <= value_in;
                    r_pend_vld <= 1'b0;
                end else if (r_pend_vld) begin
                    r_active   <= r_pending;
                    r_pend_vld <= 1'b0;
                end
            end else if (load) begin
                r_pending  <= value_in;
                r_pend_vld <= 1'b1;
            end

            r_frame_tick <= w_frame_end;
            r_an_n       <= w_lit ? w_an_sel  : AN_OFF;
            r_seg_n      <= w_lit ? w_seg_dec : SEG_OFF;
            r_dp_n       <= w_lit ? ~dp_mask[r_dig] : 1'b1;
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan
//  Description : Self-checking bench for seg7_scan (REFRESH_DIV=8,
//                GHOST_CYC=2). At each frame start the stimulus pushes the
//                lit outputs expected for that frame ({an_n,seg_n,dp_n}, six
//                lit cycles per digit) into a queue; the monitor pops one
//                entry for every lit output cycle and requires dark cycles
//                to carry seg_n=7F, dp_n=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    localparam int REFRESH_DIV = 8;
    localparam int GHOST_CYC   = 2;
    localparam int LIT_CYC     = REFRESH_DIV - GHOST_CYC;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [11:0] exp_q [$];
    logic [11:0] mon_exp;
    logic [11:0] mon_got;

    seg7_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .GHOST_CYC   (GHOST_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: exp_seg = 7'h40;  4'h1: exp_seg = 7'h79;
            4'h2: exp_seg = 7'h24;  4'h3: exp_seg = 7'h30;
            4'h4: exp_seg = 7'h19;  4'h5: exp_seg = 7'h12;
            4'h6: exp_seg = 7'h02;  4'h7: exp_seg = 7'h78;
            4'h8: exp_seg = 7'h00;  4'h9: exp_seg = 7'h10;
            4'hA: exp_seg = 7'h08;  4'hB: exp_seg = 7'h03;
            4'hC: exp_seg = 7'h46;  4'hD: exp_seg = 7'h21;
            4'hE: exp_seg = 7'h06;  default: exp_seg = 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Queue the lit cycles of one frame showing value v.
    task automatic push_frame(input logic [15:0] v, input logic blz, input logic [3:0] dpm);
        for (int k = 0; k < 4; k++) begin
            logic [3:0]  nib;
            logic [15:0] upper;
            logic [3:0]  an;
            nib   = v[k*4 +: 4];
            upper = v >> (4 * k);
            an    = ~(4'b0001 << k);
            if (!(blz && (k > 0) && (upper == 16'h0000))) begin
                repeat (LIT_CYC) exp_q.push_back({an, exp_seg(nib), ~dpm[k]});
            end
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            checks++;
            errors++;
            $display("FAIL frame_tick_timeout: got 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: every lit cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (an_n != 4'hF) begin
                mon_got = {an_n, seg_n, dp_n};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_lit: got %0h expected no lit digit", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL lit_output {an,seg,dp}: got %0h expected %0h", mon_got, mon_exp);
                    end
                end
            end else if (seg_n !== 7'h7F || dp_n !== 1'b1) begin
                errors++;
                $display("FAIL dark_output {seg,dp}: got %0h expected ff", {seg_n, dp_n});
            end
        end
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;

        // Reset behaviour
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_an_n", 32'(an_n), 32'hF);
            chk("reset_seg_n", 32'(seg_n), 32'h7F);
            chk("reset_dp_n", 32'(dp_n), 32'h1);
            chk("reset_frame_tick", 32'(frame_tick), 32'h0);
        end
        push_frame(16'h0000, 1'b0, 4'b0000);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_reset_dark", 32'(an_n), 32'hF);
        end
        @(negedge clk);
        chk("first_lit_an_n", 32'(an_n), 32'hE);
        chk("first_lit_seg_n", 32'(seg_n), 32'h40);
        wait_tick();

        // Mid-frame load: current frame still 0000, next shows 1234
        push_frame(16'h0000, 1'b0, 4'b0000);
        repeat (9) @(negedge clk);
        pulse_load(16'h1234);
        wait_tick();

        // Counter feed with blanking
        push_frame(16'h1234, 1'b0, 4'b0000);
        repeat (9) @(negedge clk);
        pulse_load(16'h0005);
        wait_tick();
        blank_lz = 1'b1;
        push_frame(16'h0005, 1'b1, 4'b0000);
        repeat (9) @(negedge clk);
        pulse_load(16'h0005);
        wait_tick();

        // Boundary collision A: load on the boundary cycle
        blank_lz = 1'b0;
        push_frame(16'h0005, 1'b0, 4'b0000);
        repeat (31) @(negedge clk);
        pulse_load(16'hABCD);
        chk("tick_after_boundary_load", 32'(frame_tick), 32'h1);

        // Boundary collision B: last load in a frame wins
        push_frame(16'hABCD, 1'b0, 4'b0000);
        repeat (5) @(negedge clk);
        pulse_load(16'h1111);
        repeat (14) @(negedge clk);
        pulse_load(16'h2222);
        wait_tick();

        // Decimal point on digit 2, then reset with a pending load
        dp_mask = 4'b0100;
        push_frame(16'h2222, 1'b0, 4'b0100);
        repeat (4) @(negedge clk);
        pulse_load(16'h7777);
        repeat (5) @(negedge clk);
        chk("slot0_consumed_before_reset", 32'(exp_q.size()), 32'd18);
        exp_q.delete();
        rst     = 1'b1;
        dp_mask = 4'b0000;
        repeat (2) @(negedge clk);
        chk("midreset_an_n", 32'(an_n), 32'hF);
        push_frame(16'h0000, 1'b0, 4'b0000);
        rst = 1'b0;
        wait_tick();
        push_frame(16'h0000, 1'b0, 4'b0000);
        wait_tick();
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
